mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch stage (IF port) and the data-memory stage (D port) of the pipelined RISC-V CPU.
- Sequences every memory access through a small FSM with a fixed memory read latency.
- Grants the data stage by default, with a starvation guard for instruction fetch.
- Exposes req/gnt/valid handshakes so the hazard logic can stall the pipeline on a missing gnt or valid.

Parameters:
- Nbits, 64, address and data width.
- LAT, 2, memory read latency in cycles from the mem_en cycle to mem_rdata valid (>=1).
- STARVE_MAX, 4, consecutive lost arbitrations after which IF is forced to win.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- if_req  in  1  IF requests an instruction read.
- if_addr  in  Nbits  IF read address.
- if_gnt  out  1  one-cycle pulse: IF request accepted.
- if_valid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  Nbits  read data for IF.
- d_req  in  1  D requests an access.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  Nbits  D address.
- d_wdata  in  Nbits  D write data.
- d_gnt  out  1  one-cycle pulse: D request accepted.
- d_valid  out  1  one-cycle pulse: read data valid or write acknowledged.
- d_rdata  out  Nbits  read data for D.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  Nbits  memory address.
- mem_wdata  out  Nbits  memory write data.
- mem_rdata  in  Nbits  memory read data, valid LAT cycles after the mem_en cycle.
- busy  out  1  FSM not in IDLE.

Behaviour:
- States:
  - IDLE: requests are sampled only here.
  - ISSUE: mem_en=1 for exactly one cycle; mem_we/addr/wdata come from latched registers.
  - WAIT: down-counter from LAT-1 to 0; reads only.
  - RESP: mem_rdata captured.
- Arbitration (IDLE, req sampled in cycle t):
  - Both ports requesting: D wins unless starve_cnt == STARVE_MAX, in which case IF wins.
  - Only one port requesting: that port wins.
  - Winner's addr/we/wdata and owner are latched at edge t+1.
  - The winner's gnt pulses in cycle t+1, and state becomes ISSUE.
- Starvation counter (starve_cnt, width clog2(STARVE_MAX+1)):
  - Increments when IF and D both request and D wins.
  - Clears when IF wins.
  - Saturates at STARVE_MAX.
- Write path: ISSUE (mem_we=1) at t+1; d_valid pulses at t+2; state is IDLE in cycle t+2.
- Read path:
  - ISSUE at t+1, then WAIT for LAT-1 cycles.
  - mem_rdata is registered at the end of cycle t+1+LAT.
  - Owner's valid and rdata are presented in cycle t+2+LAT; state is IDLE in that same cycle.
  - Request-to-valid latency is LAT+2.
  - With LAT=1, WAIT is skipped (ISSUE goes directly to RESP).
- IF port never writes; if_req is always treated as a read.
- Handshake rules:
  - A requester holds req, addr, we and wdata stable until its gnt.
  - req is ignored outside IDLE.
  - req high in a valid cycle (state IDLE) is a new request, which gives back-to-back issue.
- rdata outputs hold their last captured value.
- mem_en, mem_we, gnt and valid are 0 whenever not specified above.
- mem_addr and mem_wdata hold their latched values when mem_en=0.
- Reset (rst=0, at any time, including mid-access):
  - State goes to IDLE; all outputs, latched registers and starve_cnt go to 0.
  - The in-flight transaction is dropped with no valid.
  - A write already strobed into memory is not undone.
- Simultaneous events: a gnt can never coincide with the same port's valid; at most one gnt and one valid are high per cycle.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: when both ports request, the winner alternates. A last_owner flag (reset = IF) selects the port that did not win the previous arbitration. starve_cnt is not implemented.
- Undefined: D priority with the STARVE_MAX guard, as above.

Test Plan:
- Reset/idle: rst=0 mid-read (ISSUE cycle) then released -> no valid pulse, busy=0, all outputs 0, next request serviced normally.
- Single IF read, LAT=2: if_req=1, if_addr=0x40 at cycle 0, mem_rdata=0x00500093 in cycle 3 -> if_gnt in cycle 1; mem_en=1, mem_addr=0x40 in cycle 1; if_valid=1, if_rdata=0x00500093 in cycle 4.
- D write: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEAD at cycle 0 -> d_gnt and mem_en=mem_we=1 in cycle 1 with addr/data matching; d_valid in cycle 2; busy=0 in cycle 2.
- Contention with both ports requesting continuously, D writes back-to-back, STARVE_MAX=4 -> D granted 4 times, IF granted on the 5th arbitration, starve_cnt back to 0, then D again.
- Back-to-back reads: D read with d_req kept high through the d_valid cycle -> new ISSUE in the cycle after d_valid; no overlap of mem_en across transactions.
- ARB_ROUND_ROBIN_EN defined, both ports requesting continuously -> grant order IF? no, first D (last_owner=IF after reset), then IF, D, IF alternating.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: IF read port, D read/write port,
// memory-side strobe/address/data, and the busy status flag.
// master = requester/memory side, slave = arbiter side.
interface mem_port_arbiter_if #(
    parameter int Nbits = 64
);
    logic             if_req;
    logic [Nbits-1:0] if_addr;
    logic             if_gnt;
    logic             if_valid;
    logic [Nbits-1:0] if_rdata;

    logic             d_req;
    logic             d_we;
    logic [Nbits-1:0] d_addr;
    logic [Nbits-1:0] d_wdata;
    logic             d_gnt;
    logic             d_valid;
    logic [Nbits-1:0] d_rdata;

    logic             mem_en;
    logic             mem_we;
    logic [Nbits-1:0] mem_addr;
    logic [Nbits-1:0] mem_wdata;
    logic [Nbits-1:0] mem_rdata;

    logic             busy;

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_valid, if_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_valid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_valid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_valid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by instruction fetch (IF, read only)
// and the data stage (D, read/write). One access in flight at a time:
// IDLE -> ISSUE -> [WAIT] -> RESP for reads, IDLE -> ISSUE for writes.
// Optional macro ARB_ROUND_ROBIN_EN: alternate winners on contention
// instead of D priority with a starvation guard for IF.
module mem_port_arbiter #(
    parameter int Nbits      = 64,
    parameter int LAT        = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             grant_if, grant_d;

    logic             owner_d_reg;
    logic             we_reg;
    logic [Nbits-1:0] addr_reg;
    logic [Nbits-1:0] wdata_reg;
    logic             if_gnt_reg, d_gnt_reg;
    logic             if_valid_reg, d_valid_reg;
    logic [Nbits-1:0] if_rdata_reg, d_rdata_reg;

`ifdef ARB_ROUND_ROBIN_EN
    logic             last_d_reg;

    // Remember who won the last arbitration so contention alternates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_d_reg <= 1'b0;
        end else if (grant_if || grant_d) begin
            last_d_reg <= grant_d;
        end
    end

    // Arbitrate in IDLE: on contention pick the port that lost last time.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (state_reg == IDLE) begin
            if (bus.if_req && bus.d_req) begin
                grant_if = last_d_reg;
                grant_d  = !last_d_reg;
            end else begin
                grant_if = bus.if_req;
                grant_d  = bus.d_req;
            end
        end
    end
`else
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [SW-1:0]    starve_reg;

    // Count IF losses under contention; any IF win clears the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_reg <= '0;
        end else if (grant_if) begin
            starve_reg <= '0;
        end else if (grant_d && bus.if_req && starve_reg != STARVE_LIM) begin
            starve_reg <= starve_reg + 1'b1;
        end
    end

    // Arbitrate in IDLE: D has priority unless IF has lost too often.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (state_reg == IDLE) begin
            if (bus.if_req && bus.d_req) begin
                grant_if = (starve_reg == STARVE_LIM);
                grant_d  = (starve_reg != STARVE_LIM);
            end else begin
                grant_if = bus.if_req;
                grant_d  = bus.d_req;
            end
        end
    end
`endif

    // FSM state and latency counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic; WAIT holds for LAT-1 cycles so RESP lines up with mem_rdata.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (grant_if || grant_d) state_next = ISSUE;
            end
            ISSUE: begin
                if (we_reg) begin
                    state_next = IDLE;
                end else if (LAT == 1) begin
                    state_next = RESP;
                end else begin
                    state_next = WAIT;
                    cnt_next   = CW'(LAT - 1);
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == CW'(1)) state_next = RESP;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Latch the winning request, pulse gnt/valid, capture read data in RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_d_reg  <= 1'b0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            if_gnt_reg   <= 1'b0;
            d_gnt_reg    <= 1'b0;
            if_valid_reg <= 1'b0;
            d_valid_reg  <= 1'b0;
            if_rdata_reg <= '0;
            d_rdata_reg  <= '0;
        end else begin
            if_gnt_reg   <= grant_if;
            d_gnt_reg    <= grant_d;
            if_valid_reg <= 1'b0;
            d_valid_reg  <= 1'b0;
            if (grant_if) begin
                owner_d_reg <= 1'b0;
                we_reg      <= 1'b0;
                addr_reg    <= bus.if_addr;
            end
            if (grant_d) begin
                owner_d_reg <= 1'b1;
                we_reg      <= bus.d_we;
                addr_reg    <= bus.d_addr;
                wdata_reg   <= bus.d_wdata;
            end
            if (state_reg == ISSUE && we_reg) begin
                d_valid_reg <= 1'b1;
            end
            if (state_reg == RESP) begin
                if (owner_d_reg) begin
                    d_valid_reg <= 1'b1;
                    d_rdata_reg <= bus.mem_rdata;
                end else begin
                    if_valid_reg <= 1'b1;
                    if_rdata_reg <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.mem_en    = (state_reg == ISSUE);
    assign bus.mem_we    = (state_reg == ISSUE) && we_reg;
    assign bus.mem_addr  = addr_reg;
    assign bus.mem_wdata = wdata_reg;
    assign bus.busy      = (state_reg != IDLE);
    assign bus.if_gnt    = if_gnt_reg;
    assign bus.d_gnt     = d_gnt_reg;
    assign bus.if_valid  = if_valid_reg;
    assign bus.d_valid   = d_valid_reg;
    assign bus.if_rdata  = if_rdata_reg;
    assign bus.d_rdata   = d_rdata_reg;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level timing/arbitration model.
module tb_mem_port_arbiter;
    localparam int NB  = 64;
    localparam int LAT = 2;
    localparam int SM  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    mem_port_arbiter_if #(.Nbits(NB)) bus ();

    mem_port_arbiter #(.Nbits(NB), .LAT(LAT), .STARVE_MAX(SM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory model: reads answered LAT cycles after the mem_en cycle, junk otherwise.
    logic [63:0] mem_arr [logic [63:0]];
    logic        rp_v [0:LAT] = '{default: 1'b0};
    logic [63:0] rp_a [0:LAT] = '{default: 64'h0};

    function automatic logic [63:0] init_val(input logic [63:0] a);
        return {a[31:0] ^ 32'h5a5a_1234, ~a[31:0]};
    endfunction

    function automatic logic [63:0] mem_read(input logic [63:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return init_val(a);
    endfunction

    always begin
        @(posedge clk);
        #1;
        for (int i = LAT; i > 0; i--) begin
            rp_v[i] = rp_v[i-1];
            rp_a[i] = rp_a[i-1];
        end
        rp_v[0] = bus.mem_en && !bus.mem_we;
        rp_a[0] = bus.mem_addr;
        if (bus.mem_en && bus.mem_we) mem_arr[bus.mem_addr] = bus.mem_wdata;
        if (rp_v[LAT]) bus.mem_rdata = mem_read(rp_a[LAT]);
        else           bus.mem_rdata = {$urandom, $urandom};
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.mem_rdata = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        total++;
        if ({bus.busy, bus.mem_en, bus.mem_we, bus.if_gnt, bus.d_gnt, bus.if_valid, bus.d_valid} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got=%b want=0000000",
                {bus.busy, bus.mem_en, bus.mem_we, bus.if_gnt, bus.d_gnt, bus.if_valid, bus.d_valid});
        end
        total++;
        if (bus.mem_addr !== 64'h0 || bus.mem_wdata !== 64'h0) begin
            bad++;
            $display("FAIL reset_mem_bus: got addr=%h wdata=%h want 0", bus.mem_addr, bus.mem_wdata);
        end
        total++;
        if (bus.if_rdata !== 64'h0 || bus.d_rdata !== 64'h0) begin
            bad++;
            $display("FAIL reset_rdata: got if=%h d=%h want 0", bus.if_rdata, bus.d_rdata);
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_if_read();
        mem_arr[64'h40] = 64'h0050_0093;
        bus.if_req  = 1'b1;
        bus.if_addr = 64'h40;
        tick();
        total++;
        if ({bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we} !== 4'b1010) begin
            bad++;
            $display("FAIL if_read_issue: got gnt_if/gnt_d/en/we=%b want 1010",
                {bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we});
        end
        total++;
        if (bus.mem_addr !== 64'h40) begin
            bad++;
            $display("FAIL if_read_addr: got=%h want=40", bus.mem_addr);
        end
        bus.if_req = 1'b0;
        for (int c = 2; c <= LAT + 1; c++) begin
            tick();
            total++;
            if ({bus.if_valid, bus.busy, bus.mem_en} !== 3'b010) begin
                bad++;
                $display("FAIL if_read_wait c=%0d: got valid/busy/en=%b want 010", c,
                    {bus.if_valid, bus.busy, bus.mem_en});
            end
        end
        tick();
        total++;
        if ({bus.if_valid, bus.busy} !== 2'b10 || bus.if_rdata !== 64'h0050_0093) begin
            bad++;
            $display("FAIL if_read_resp: got valid/busy=%b rdata=%h want 10 00500093",
                {bus.if_valid, bus.busy}, bus.if_rdata);
        end
        tick();
        total++;
        if (bus.if_valid !== 1'b0 || bus.if_rdata !== 64'h0050_0093) begin
            bad++;
            $display("FAIL if_read_hold: got valid=%b rdata=%h want 0 00500093", bus.if_valid, bus.if_rdata);
        end
        $display("test_if_read done");
    endtask

    task automatic test_d_write();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 64'h100;
        bus.d_wdata = 64'hDEAD;
        tick();
        total++;
        if ({bus.d_gnt, bus.if_gnt, bus.mem_en, bus.mem_we} !== 4'b1011) begin
            bad++;
            $display("FAIL d_write_issue: got gnt_d/gnt_if/en/we=%b want 1011",
                {bus.d_gnt, bus.if_gnt, bus.mem_en, bus.mem_we});
        end
        total++;
        if (bus.mem_addr !== 64'h100 || bus.mem_wdata !== 64'hDEAD) begin
            bad++;
            $display("FAIL d_write_bus: got addr=%h data=%h want 100 dead", bus.mem_addr, bus.mem_wdata);
        end
        idle_inputs();
        tick();
        total++;
        if ({bus.d_valid, bus.busy, bus.mem_en, bus.d_gnt} !== 4'b1000) begin
            bad++;
            $display("FAIL d_write_ack: got valid/busy/en/gnt=%b want 1000",
                {bus.d_valid, bus.busy, bus.mem_en, bus.d_gnt});
        end
        tick();
        $display("test_d_write done");
    endtask

    task automatic test_contention();
        int exp_order[6];
        int ng;
        int got_port;
`ifdef ARB_ROUND_ROBIN_EN
        exp_order[0] = 1; exp_order[1] = 0; exp_order[2] = 1;
        exp_order[3] = 0; exp_order[4] = 1; exp_order[5] = 0;
`else
        exp_order[0] = 1; exp_order[1] = 1; exp_order[2] = 1;
        exp_order[3] = 1; exp_order[4] = 0; exp_order[5] = 1;
`endif
        do_reset();
        ng = 0;
        bus.if_req  = 1'b1;
        bus.if_addr = 64'h200;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 64'h400;
        bus.d_wdata = {$urandom, $urandom};
        for (int c = 0; c < 100 && ng < 6; c++) begin
            tick();
            if (bus.if_gnt === 1'b1 && bus.d_gnt === 1'b1) begin
                total++;
                bad++;
                $display("FAIL contention_double_gnt c=%0d: got both gnt want one", c);
            end
            got_port = -1;
            if (bus.d_gnt === 1'b1) begin
                got_port = 1;
                bus.d_addr  = bus.d_addr + 64'h8;
                bus.d_wdata = {$urandom, $urandom};
            end else if (bus.if_gnt === 1'b1) begin
                got_port = 0;
                bus.if_addr = bus.if_addr + 64'h4;
            end
            if (got_port >= 0) begin
                total++;
                if (got_port != exp_order[ng]) begin
                    bad++;
                    $display("FAIL contention_order grant#%0d: got port=%0d want port=%0d (0=IF 1=D)",
                        ng, got_port, exp_order[ng]);
                end
                $display("contention grant#%0d port=%0d", ng, got_port);
                ng++;
            end
        end
        if (ng < 6) begin
            total++;
            bad++;
            $display("FAIL contention_timeout: got %0d grants want 6", ng);
        end
        idle_inputs();
        for (int c = 0; c < LAT + 4; c++) tick();
        $display("test_contention done");
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_data;
        logic e_gnt, e_val, e_busy;
        exp_data = init_val(64'h300);
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 64'h300;
        for (int c = 1; c <= 2 * LAT + 5; c++) begin
            tick();
            e_gnt  = (c == 1) || (c == LAT + 3);
            e_val  = (c == LAT + 2) || (c == 2 * LAT + 4);
            e_busy = !((c == LAT + 2) || (c >= 2 * LAT + 4));
            total++;
            if ({bus.d_gnt, bus.mem_en, bus.d_valid, bus.busy} !== {e_gnt, e_gnt, e_val, e_busy}) begin
                bad++;
                $display("FAIL b2b_ctrl c=%0d: got gnt/en/valid/busy=%b want %b", c,
                    {bus.d_gnt, bus.mem_en, bus.d_valid, bus.busy}, {e_gnt, e_gnt, e_val, e_busy});
            end
            if (e_val) begin
                total++;
                if (bus.d_rdata !== exp_data) begin
                    bad++;
                    $display("FAIL b2b_rdata c=%0d: got=%h want=%h", c, bus.d_rdata, exp_data);
                end
            end
            if (c == LAT + 3) bus.d_req = 1'b0;
        end
        idle_inputs();
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid_read();
        bus.if_req  = 1'b1;
        bus.if_addr = 64'h48;
        tick();
        total++;
        if (bus.mem_en !== 1'b1) begin
            bad++;
            $display("FAIL midrst_issue: got mem_en=%b want 1", bus.mem_en);
        end
        bus.if_req = 1'b0;
        #2 rst = 1'b0;
        #1;
        total++;
        if ({bus.busy, bus.mem_en, bus.if_gnt, bus.if_valid} !== 4'b0 || bus.mem_addr !== 64'h0 ||
            bus.if_rdata !== 64'h0 || bus.d_rdata !== 64'h0) begin
            bad++;
            $display("FAIL midrst_clear: got busy/en/gnt/valid=%b addr=%h if_rdata=%h d_rdata=%h want all 0",
                {bus.busy, bus.mem_en, bus.if_gnt, bus.if_valid}, bus.mem_addr, bus.if_rdata, bus.d_rdata);
        end
        tick();
        tick();
        rst = 1'b1;
        for (int c = 0; c < 2 * LAT + 4; c++) begin
            tick();
            total++;
            if ({bus.if_valid, bus.d_valid, bus.busy} !== 3'b000) begin
                bad++;
                $display("FAIL midrst_dropped c=%0d: got valid_if/valid_d/busy=%b want 000", c,
                    {bus.if_valid, bus.d_valid, bus.busy});
            end
        end
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 64'h50;
        tick();
        total++;
        if (bus.d_gnt !== 1'b1) begin
            bad++;
            $display("FAIL midrst_next_gnt: got=%b want=1", bus.d_gnt);
        end
        idle_inputs();
        for (int c = 2; c <= LAT + 2; c++) tick();
        total++;
        if (bus.d_valid !== 1'b1 || bus.d_rdata !== init_val(64'h50)) begin
            bad++;
            $display("FAIL midrst_next_resp: got valid=%b rdata=%h want 1 %h",
                bus.d_valid, bus.d_rdata, init_val(64'h50));
        end
        tick();
        $display("test_reset_mid_read done");
    endtask

    // Randomized traffic against a transaction-timing model.
    task automatic test_random();
        logic [63:0] ref_mem [logic [63:0]];
        int free_c, gnt_c, val_c, gnt_port, val_port, starve, w;
        bit last_d_won, if_pend, d_pend, exp_we;
        logic [63:0] exp_addr, exp_wdata, exp_data, last_if, last_d;
        logic e_if_gnt, e_d_gnt, e_en, e_if_val, e_d_val, e_busy;
        int ntx;
        do_reset();
        free_c = 0; gnt_c = -1; val_c = -1; gnt_port = 0; val_port = 0;
        starve = 0; last_d_won = 1'b0; if_pend = 1'b0; d_pend = 1'b0;
        exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; exp_data = '0;
        last_if = '0; last_d = '0; ntx = 0;
        for (int n = 0; n < 1500; n++) begin
            e_if_gnt = (n == gnt_c) && (gnt_port == 0);
            e_d_gnt  = (n == gnt_c) && (gnt_port == 1);
            e_en     = (n == gnt_c);
            e_if_val = (n == val_c) && (val_port == 0);
            e_d_val  = (n == val_c) && (val_port == 1);
            e_busy   = (n < free_c);
            if (e_if_val) last_if = exp_data;
            if (e_d_val && !exp_we) last_d = exp_data;
            total++;
            if ({bus.if_gnt, bus.d_gnt, bus.if_valid, bus.d_valid, bus.mem_en, bus.busy} !==
                {e_if_gnt, e_d_gnt, e_if_val, e_d_val, e_en, e_busy}) begin
                bad++;
                $display("FAIL rand_ctrl n=%0d: got gi/gd/vi/vd/en/busy=%b want %b", n,
                    {bus.if_gnt, bus.d_gnt, bus.if_valid, bus.d_valid, bus.mem_en, bus.busy},
                    {e_if_gnt, e_d_gnt, e_if_val, e_d_val, e_en, e_busy});
            end
            total++;
            if (bus.if_rdata !== last_if || bus.d_rdata !== last_d) begin
                bad++;
                $display("FAIL rand_rdata n=%0d: got if=%h d=%h want if=%h d=%h", n,
                    bus.if_rdata, bus.d_rdata, last_if, last_d);
            end
            if (e_en) begin
                total++;
                if (bus.mem_we !== exp_we || bus.mem_addr !== exp_addr ||
                    (exp_we && bus.mem_wdata !== exp_wdata)) begin
                    bad++;
                    $display("FAIL rand_membus n=%0d: got we=%b addr=%h wdata=%h want we=%b addr=%h wdata=%h",
                        n, bus.mem_we, bus.mem_addr, bus.mem_wdata, exp_we, exp_addr, exp_wdata);
                end
            end
            if (e_if_val || e_d_val) begin
                $display("rand txn#%0d n=%0d port=%0d we=%0d addr=%h data=%h", ntx, n,
                    val_port, exp_we, exp_addr, exp_we ? exp_wdata : exp_data);
                ntx++;
            end
            if (e_if_gnt) if_pend = 1'b0;
            if (e_d_gnt)  d_pend  = 1'b0;
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend     = 1'b1;
                bus.if_addr = 64'h10000 + 64'(8 * $urandom_range(0, 15));
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend      = 1'b1;
                bus.d_we    = $urandom_range(0, 1) == 1;
                bus.d_addr  = 64'h10000 + 64'(8 * $urandom_range(0, 15));
                bus.d_wdata = {$urandom, $urandom};
            end
            bus.if_req = if_pend;
            bus.d_req  = d_pend;
            if (n >= free_c && (if_pend || d_pend)) begin
                if (if_pend && d_pend) begin
`ifdef ARB_ROUND_ROBIN_EN
                    w = last_d_won ? 0 : 1;
`else
                    w = (starve == SM) ? 0 : 1;
                    if (w == 1 && starve < SM) starve++;
`endif
                end else begin
                    w = d_pend ? 1 : 0;
                end
                if (w == 0) starve = 0;
                last_d_won = (w == 1);
                gnt_c    = n + 1;
                gnt_port = w;
                val_port = w;
                exp_we   = (w == 1) ? bus.d_we : 1'b0;
                exp_addr = (w == 1) ? bus.d_addr : bus.if_addr;
                exp_wdata = bus.d_wdata;
                if (exp_we) begin
                    ref_mem[exp_addr] = exp_wdata;
                    val_c = n + 2;
                end else begin
                    exp_data = ref_mem.exists(exp_addr) ? ref_mem[exp_addr] : init_val(exp_addr);
                    val_c = n + 2 + LAT;
                end
                free_c = val_c;
            end
            tick();
        end
        idle_inputs();
        for (int c = 0; c < LAT + 4; c++) tick();
        $display("test_random done: %0d transactions", ntx);
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_d_write();
        test_contention();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
